// File: rtl/pmt_count_buffer.sv
// pmt_count_buffer: buffers PMT count readings together with a snapshot of the
// laser-lock error flags. On a sequencer send request, the buffered readings
// are drained as a 5-byte-per-record stream, and the block then holds a level
// acknowledge until the request drops.
module pmt_count_buffer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              iCLOCK,
  input  logic              iRESET,
  input  logic              iCountReady,
  input  logic [31:0]       iCountData,
  input  logic [15:0]       iErrorSignal,
  input  logic              iSendData,
  output logic              oFinishedSendingData,
  output logic [7:0]        oTxData,
  output logic              oTxValid,
  input  logic              iTxReady,
  output logic [ADDR_W:0]   oFill,
  output logic              oOverflow
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t            state, stateNext;
  logic [35:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wrPtr, rdPtr;
  logic [ADDR_W:0]   remaining;
  logic [39:0]       shiftReg;
  logic [2:0]        byteIdx;

  logic wrEn, popEn, xfer, lastByte, full;
  logic txValidNext, finishedNext;

  // Only the four lock flags are kept; the upper error bits are ignored.
  logic unusedErrBits;
  assign unusedErrBits = ^iErrorSignal[15:4];

  assign full     = (oFill == (ADDR_W+1)'(DEPTH));
  assign wrEn     = iCountReady && !full;
  assign xfer     = oTxValid && iTxReady;
  assign lastByte = (byteIdx == 3'd4);

  // State register.
  always_ff @(posedge iCLOCK) begin
    if (iRESET) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state logic for the drain sequence.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:  if (iSendData) stateNext = LOAD;
      LOAD:  stateNext = (remaining == '0) ? DONE : SHIFT;
      SHIFT: if (xfer && lastByte) stateNext = LOAD;
      DONE:  if (!iSendData) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Output decode: pop strobe and next values of the registered outputs.
  always_comb begin
    popEn        = (state == LOAD) && (remaining != '0);
    txValidNext  = (stateNext == SHIFT);
    finishedNext = (stateNext == DONE);
  end

  // Record storage; the pointer discipline keeps reads and writes apart.
  always_ff @(posedge iCLOCK) begin
    if (wrEn) mem[wrPtr] <= {iErrorSignal[3:0], iCountData};
  end

  // Pointers, fill level and sticky overflow.
  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      oFill     <= '0;
      oOverflow <= 1'b0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + 1'b1;
      if (popEn) rdPtr <= rdPtr + 1'b1;
      if (iCountReady && full) oOverflow <= 1'b1;
      case ({wrEn, popEn})
        2'b10:   oFill <= oFill + 1'b1;
        2'b01:   oFill <= oFill - 1'b1;
        default: oFill <= oFill;
      endcase
    end
  end

  // Burst length is frozen at request time so late writes wait for the next burst.
  always_ff @(posedge iCLOCK) begin
    if (iRESET)                          remaining <= '0;
    else if (state == IDLE && iSendData) remaining <= oFill;
    else if (popEn)                      remaining <= remaining - 1'b1;
  end

  // Byte serialiser: oTxData always shows the current byte; the shift register
  // holds the record with the next byte sitting just below the top.
  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      shiftReg             <= '0;
      byteIdx              <= '0;
      oTxData              <= '0;
      oTxValid             <= 1'b0;
      oFinishedSendingData <= 1'b0;
    end else begin
      oTxValid             <= txValidNext;
      oFinishedSendingData <= finishedNext;
      if (popEn) begin
        shiftReg <= {mem[rdPtr][31:0], 4'b0000, mem[rdPtr][35:32]};
        oTxData  <= mem[rdPtr][31:24];
        byteIdx  <= '0;
      end else if (state == SHIFT && xfer) begin
        shiftReg <= {shiftReg[31:0], 8'h00};
        byteIdx  <= byteIdx + 3'd1;
        if (!lastByte) oTxData <= shiftReg[31:24];
      end
    end
  end

endmodule

// File: tb/tb_pmt_count_buffer.sv
// Directed/randomised bench for pmt_count_buffer; a queue of records models the
// buffer contents and the expected byte stream is derived from it.
module tb_pmt_count_buffer;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              iCLOCK = 1'b0;
  logic              iRESET = 1'b1;
  logic              iCountReady = 1'b0;
  logic [31:0]       iCountData = '0;
  logic [15:0]       iErrorSignal = '0;
  logic              iSendData = 1'b0;
  logic              oFinishedSendingData;
  logic [7:0]        oTxData;
  logic              oTxValid;
  logic              iTxReady = 1'b1;
  logic [ADDR_W:0]   oFill;
  logic              oOverflow;

  pmt_count_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .iCLOCK(iCLOCK), .iRESET(iRESET), .iCountReady(iCountReady),
    .iCountData(iCountData), .iErrorSignal(iErrorSignal), .iSendData(iSendData),
    .oFinishedSendingData(oFinishedSendingData), .oTxData(oTxData),
    .oTxValid(oTxValid), .iTxReady(iTxReady), .oFill(oFill), .oOverflow(oOverflow)
  );

  always #5 iCLOCK = ~iCLOCK;

  int nChecks = 0;
  int nErrors = 0;
  logic [35:0] mq[$];
  bit ovf = 1'b0;

  task automatic tick;
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] recByte(input logic [35:0] r, input int k);
    case (k)
      0: return r[31:24];
      1: return r[23:16];
      2: return r[15:8];
      3: return r[7:0];
      default: return {4'b0000, r[35:32]};
    endcase
  endfunction

  task automatic driveRec(input logic [35:0] rec);
    logic [15:0] e;
    e = 16'($urandom);
    e[3:0] = rec[35:32];
    iErrorSignal = e;
    iCountData = rec[31:0];
    iCountReady = 1'b1;
  endtask

  task automatic put(input logic [35:0] rec);
    driveRec(rec);
    tick;
    iCountReady = 1'b0;
    if (mq.size() < DEPTH) mq.push_back(rec);
    else ovf = 1'b1;
    chk("fill_after_write", oFill, mq.size());
    chk("ovf_after_write", oOverflow, ovf);
  endtask

  task automatic checkReset(input string tag);
    chk({tag, " txData"}, oTxData, 0);
    chk({tag, " txValid"}, oTxValid, 0);
    chk({tag, " finished"}, oFinishedSendingData, 0);
    chk({tag, " fill"}, oFill, 0);
    chk({tag, " overflow"}, oOverflow, 0);
  endtask

  // Request a drain and follow it to completion. lateAt >= 0 injects one write
  // while the byte with that index is on the bus.
  task automatic drain(input bit randReady, input int lateAt, input string tag);
    int n;
    int got;
    int cyc;
    bit done;
    bit lateDone;
    bit stalled;
    logic [7:0] lastData;
    logic [7:0] exp[$];
    logic [35:0] r;
    n = mq.size();
    got = 0; cyc = 0; done = 0; lateDone = 0; stalled = 0; lastData = '0;
    for (int i = 0; i < n; i++) begin
      r = mq.pop_front();
      for (int k = 0; k < 5; k++) exp.push_back(recByte(r, k));
    end
    iSendData = 1'b1;
    iTxReady = 1'b1;
    while (!done && cyc < 100 * n + 50) begin
      tick;
      cyc++;
      iCountReady = 1'b0;
      if (cyc == 1) chk({tag, " load_no_valid"}, oTxValid, 0);
      if (cyc == 2) chk({tag, " first_out"}, (n > 0) ? oTxValid : oFinishedSendingData, 1);
      if (oFinishedSendingData) begin
        done = 1;
        chk({tag, " done_no_valid"}, oTxValid, 0);
      end else if (oTxValid) begin
        if (stalled) chk({tag, " stable"}, oTxData, lastData);
        if (got < exp.size()) chk({tag, " byte"}, oTxData, exp[got]);
        else chk({tag, " extra_byte"}, got, exp.size());
        iTxReady = randReady ? 1'($urandom) : 1'b1;
        stalled = !iTxReady;
        lastData = oTxData;
        if (lateAt >= 0 && !lateDone && got == lateAt) begin
          r = {4'($urandom), 32'($urandom)};
          driveRec(r);
          mq.push_back(r);
          lateDone = 1;
        end
        if (iTxReady) got++;
      end else begin
        stalled = 0;
      end
    end
    iCountReady = 1'b0;
    chk({tag, " finished_seen"}, done, 1);
    chk({tag, " byte_count"}, got, exp.size());
    if (!randReady) chk({tag, " cycles"}, cyc, 2 + 6 * n);
    repeat (2) begin
      tick;
      chk({tag, " finished_hold"}, oFinishedSendingData, 1);
    end
    iSendData = 1'b0;
    tick;
    chk({tag, " finished_drop"}, oFinishedSendingData, 0);
    chk({tag, " idle_no_valid"}, oTxValid, 0);
    chk({tag, " fill_end"}, oFill, mq.size());
    chk({tag, " overflow_end"}, oOverflow, ovf);
  endtask

  initial begin
    logic [35:0] first;
    // Reset
    repeat (3) tick;
    iRESET = 1'b0;
    tick;
    checkReset("reset");

    // Single known record
    put({4'h5, 32'h12345678});
    drain(1'b0, -1, "single");

    // Empty drain
    drain(1'b0, -1, "empty");

    // Backpressure over three random records
    for (int i = 0; i < 3; i++) put({4'($urandom), 32'($urandom)});
    drain(1'b1, -1, "backpressure");

    // Write arriving during the drain of record 1
    for (int i = 0; i < 2; i++) put({4'($urandom), 32'($urandom)});
    drain(1'b1, 2, "concurrent");
    chk("concurrent fill_one", oFill, 1);
    drain(1'b0, -1, "late_record");

    // Overflow: one strobe more than capacity
    for (int i = 0; i < DEPTH + 1; i++) put({4'($urandom), 32'($urandom)});
    chk("overflow fill_full", oFill, DEPTH);
    chk("overflow flag", oOverflow, 1);
    drain(1'b0, -1, "overflow_drain");

    // Reset during byte 2 of the first of four records
    for (int i = 0; i < 4; i++) put({4'($urandom), 32'($urandom)});
    first = mq[0];
    iSendData = 1'b1;
    iTxReady = 1'b1;
    repeat (4) tick;
    chk("midburst byte2", oTxData, recByte(first, 2));
    chk("midburst valid", oTxValid, 1);
    iRESET = 1'b1;
    iSendData = 1'b0;
    tick;
    checkReset("midburst_reset");
    iRESET = 1'b0;
    mq.delete();
    ovf = 1'b0;
    tick;
    drain(1'b0, -1, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
